// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Convert a one-hot requester vector to its index; zero input yields 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4to1_8bit.sv
// Existing 8-bit 4-to-1 multiplexer; select index is {S1,S0}.
module mux4to1_8bit (
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic       S1,
  input  logic       S0,
  output logic [7:0] Y
);

  // Pure combinational select.
  always_comb begin
    case ({S1, S0})
      2'b00:   Y = I0;
      2'b01:   Y = I1;
      2'b10:   Y = I2;
      default: Y = I3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four producers a bounded burst on a
// shared 8-bit valid/ready channel; the data path is the existing 4:1 mux.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  d0,
  input  logic [DATA_W-1:0]  d1,
  input  logic [DATA_W-1:0]  d2,
  input  logic [DATA_W-1:0]  d3,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready
);

  localparam int unsigned     CntW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [1:0]         scan_idx;
  logic               found;
  logic               xfer;
  logic [DATA_W-1:0]  mux_y;

  // Pick the first requester at or after ptr, wrapping 3 -> 0.
  always_comb begin
    win_oh   = '0;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        win_oh = 4'b0001 << scan_idx;
      end
    end
  end

  // Channel outputs: valid follows the owner's request, data gated to zero when idle.
  always_comb begin
    out_valid = (state_q == StGrant) && req[sel_q];
    xfer      = out_valid && out_ready;
    ack       = gnt_q & {NUM_REQ{xfer}};
    out_data  = out_valid ? mux_y : '0;
    gnt       = gnt_q;
    sel       = sel_q;
  end

  // Next-state: grant from idle; release on last beat or owner withdrawal.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = win_oh;
          sel_d   = onehot_to_idx(win_oh);
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (!out_valid || (out_ready && (cnt_q == LastBeat))) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
        end else if (out_ready) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; sel is held across idle until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  mux4to1_8bit u_mux (
    .I0 (d0),
    .I1 (d1),
    .I2 (d2),
    .I3 (d3),
    .S1 (sel_q[1]),
    .S0 (sel_q[0]),
    .Y  (mux_y)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_BURST=4 and 1), a behavioural
// model checked every cycle, a vector table and directed corner sequences.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic       rdy_a, rdy_b;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] ack_a, gnt_a, ack_b, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance: owner (-1 = idle), pointer, beats done, never-granted flag.
  int m_owner[2];
  int m_ptr[2];
  int m_beats[2];
  bit m_fresh[2];
  int mb[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req       (req_a),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .ack       (ack_a),
    .gnt       (gnt_a),
    .sel       (sel_a),
    .out_valid (valid_a),
    .out_data  (data_a),
    .out_ready (rdy_a)
  );

  mux4_rr_arbiter #(.MAX_BURST(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req       (req_b),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .ack       (ack_b),
    .gnt       (gnt_b),
    .sel       (sel_b),
    .out_valid (valid_b),
    .out_data  (data_b),
    .out_ready (rdy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare one instance against the model's view of the current cycle.
  task automatic check_one(input int k, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [7:0] dat, input logic [3:0] a,
                           input logic [3:0] rq, input logic rd);
    logic [7:0]  dv[4];
    logic [31:0] eg, ev, ea, ed;
    int          o;
    string       p;
    dv = '{d0, d1, d2, d3};
    o  = m_owner[k];
    p  = (k == 0) ? "a" : "b";
    eg = '0;
    ev = '0;
    ea = '0;
    ed = '0;
    if (o >= 0) begin
      eg = 32'(1) << o;
      ev = 32'(rq[o]);
      if (rq[o]) ed = 32'(dv[o]);
      if (rq[o] && rd) ea = eg;
    end
    chk({p, "_gnt"}, 32'(g), eg);
    chk({p, "_valid"}, 32'(v), ev);
    chk({p, "_data"}, 32'(dat), ed);
    chk({p, "_ack"}, 32'(a), ea);
    if (o >= 0) chk({p, "_sel"}, 32'(s), 32'(o));
    else if (m_fresh[k]) chk({p, "_sel_reset"}, 32'(s), 32'd0);
  endtask

  // Advance the model by one clock edge using the rules of the arbiter.
  task automatic model_step(input int k, input logic [3:0] rq, input logic rd);
    bit found;
    int j;
    if (rst) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_beats[k] = 0;
      m_fresh[k] = 1'b1;
    end else if (m_owner[k] < 0) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        j = (m_ptr[k] + i) % 4;
        if (!found && rq[j]) begin
          found      = 1'b1;
          m_owner[k] = j;
          m_beats[k] = 0;
          m_fresh[k] = 1'b0;
        end
      end
    end else if (!rq[m_owner[k]]) begin
      m_ptr[k]   = (m_owner[k] + 1) % 4;
      m_owner[k] = -1;
    end else if (rd) begin
      m_beats[k]++;
      if (m_beats[k] == mb[k]) begin
        m_ptr[k]   = (m_owner[k] + 1) % 4;
        m_owner[k] = -1;
      end
    end
  endtask

  // One cycle: check at the falling edge, update model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_one(0, gnt_a, sel_a, valid_a, data_a, ack_a, req_a, rdy_a);
    check_one(1, gnt_b, sel_b, valid_b, data_b, ack_b, req_b, rdy_b);
    @(posedge clk);
    model_step(0, req_a, rdy_a);
    model_step(1, req_b, rdy_b);
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int         acks;
    bit         done;
    logic [3:0] eg;
    logic [7:0] rr_data[5];

    mb       = '{4, 1};
    m_owner  = '{-1, -1};
    m_ptr    = '{0, 0};
    m_beats  = '{0, 0};
    m_fresh  = '{1'b1, 1'b1};
    rr_data  = '{8'h55, 8'h0F, 8'hF0, 8'h7F, 8'h55};

    // Single burst on requester 0 (MAX_BURST=4), then a withdrawal.
    tbl[0] = '{4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 4'b0000, 8'h00};
    for (int i = 1; i <= 4; i++) tbl[i] = '{4'b0001, 1'b1, 4'b0001, 2'b00, 1'b1, 4'b0001, 8'h55};
    tbl[5] = '{4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 4'b0000, 8'h00};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 2'b00, 1'b1, 4'b0001, 8'h55};
    tbl[7] = '{4'b0000, 1'b1, 4'b0001, 2'b00, 1'b0, 4'b0000, 8'h00};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 4'b0000, 8'h00};

    rst   = 1'b1;
    req_a = 4'hF;
    req_b = 4'hF;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    d0    = 8'h55;
    d1    = 8'h0F;
    d2    = 8'hF0;
    d3    = 8'h7F;

    // Reset held two cycles with all requests up.
    @(posedge clk);
    model_step(0, req_a, rdy_a);
    model_step(1, req_b, rdy_b);
    #1;
    chk("reset_gnt", 32'(gnt_a), 32'd0);
    chk("reset_sel", 32'(sel_a), 32'd0);
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_data", 32'(data_a), 32'd0);
    chk("reset_ack", 32'(ack_a), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("first_grant_r0", 32'(gnt_a), 32'h1);
    req_a = '0;
    req_b = '0;
    step();
    step();

    // Table-driven single burst.
    foreach (tbl[i]) begin
      req_a = tbl[i].req;
      rdy_a = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_ack", i), 32'(ack_a), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_data", i), 32'(data_a), 32'(tbl[i].data));
      if (tbl[i].gnt != 4'b0) chk($sformatf("tbl%0d_sel", i), 32'(sel_a), 32'(tbl[i].sel));
      step();
    end

    // Backpressure on requester 2.
    req_a = 4'b0100;
    rdy_a = 1'b1;
    step();
    chk("bp_gnt", 32'(gnt_a), 32'h4);
    chk("bp_sel", 32'(sel_a), 32'h2);
    acks = (ack_a[2]) ? 1 : 0;
    step();
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_valid", 32'(valid_a), 32'h1);
      chk("bp_stall_data", 32'(data_a), 32'hF0);
      chk("bp_stall_ack", 32'(ack_a), 32'h0);
      chk("bp_stall_gnt", 32'(gnt_a), 32'h4);
      step();
    end
    rdy_a = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (gnt_a == 4'b0) done = 1'b1;
      else begin
        if (ack_a[2]) acks++;
        step();
      end
    end
    chk("bp_burst_ended", 32'(done), 32'h1);
    chk("bp_ack_total", 32'(acks), 32'd4);

    // Withdrawal: park pointer at 1, then requester 1 drops after 2 beats.
    req_a = 4'b0001;
    step();
    req_a = 4'b0000;
    step();
    req_a = 4'b1010;
    step();
    chk("wd_gnt_r1", 32'(gnt_a), 32'h2);
    chk("wd_sel_r1", 32'(sel_a), 32'h1);
    chk("wd_ack1", 32'(ack_a), 32'h2);
    step();
    chk("wd_ack2", 32'(ack_a), 32'h2);
    step();
    req_a = 4'b1000;
    #1;
    chk("wd_valid_drop", 32'(valid_a), 32'h0);
    chk("wd_ack_drop", 32'(ack_a), 32'h0);
    step();
    chk("wd_idle", 32'(gnt_a), 32'h0);
    step();
    chk("wd_gnt_r3", 32'(gnt_a), 32'h8);
    chk("wd_sel_r3", 32'(sel_a), 32'h3);
    chk("wd_data_r3", 32'(data_a), 32'h7F);

    // Reset during beat 2 of requester 3.
    step();
    rst   = 1'b1;
    req_a = 4'b1001;
    step();
    rst = 1'b0;
    #1;
    chk("rmb_gnt", 32'(gnt_a), 32'h0);
    chk("rmb_sel", 32'(sel_a), 32'h0);
    chk("rmb_valid", 32'(valid_a), 32'h0);
    chk("rmb_data", 32'(data_a), 32'h0);
    chk("rmb_ack", 32'(ack_a), 32'h0);
    step();
    chk("rmb_gnt_r0", 32'(gnt_a), 32'h1);
    req_a = '0;
    step();
    step();

    // Round-robin on the MAX_BURST=1 instance.
    req_b = 4'hF;
    rdy_b = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      #1;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt_b), 32'(eg));
      chk($sformatf("rr%0d_sel", k), 32'(sel_b), 32'(k % 4));
      chk($sformatf("rr%0d_data", k), 32'(data_b), 32'(rr_data[k]));
      chk($sformatf("rr%0d_ack", k), 32'(ack_b), 32'(eg));
      step();
      chk($sformatf("rr%0d_idle", k), 32'(gnt_b), 32'h0);
      step();
    end
    req_b = '0;
    step();
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(99) == 0);
      req_a = 4'($urandom) | 4'($urandom);
      req_b = 4'($urandom) | 4'($urandom);
      rdy_a = ($urandom_range(3) != 0);
      rdy_b = ($urandom_range(3) != 0);
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      d2    = 8'($urandom);
      d3    = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
